// File: rtl/clock_pkg.sv
// Shared definitions for the time-keeping block: field widths, mode
// indices, the mode-button FSM states and a helper for mode index width.
package clock_pkg;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam int MODE_CLOCK     = 0;
  localparam int MODE_STOPWATCH = 1;
  localparam int MODE_TIMER     = 2;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } mode_state_e;

  // Width of a mode index; a single mode still needs one bit.
  function automatic int mode_w(input int n_modes);
    return (n_modes > 1) ? $clog2(n_modes) : 1;
  endfunction

endpackage

// File: rtl/mode_hub_if.sv
// Front-panel / mode-module bundle seen by mode_hub: level buttons and
// packed per-mode time fields in, routed pulses and display fields out.
interface mode_hub_if #(
  parameter int N_MODES = 3
);
  import clock_pkg::*;

  localparam int MW = mode_w(N_MODES);

  logic                     i_mode;
  logic                     i_set;
  logic                     i_up;
  logic                     i_down;
  logic                     i_left;
  logic                     i_right;
  logic [SEC_W*N_MODES-1:0] i_sec_bus;
  logic [MIN_W*N_MODES-1:0] i_min_bus;
  logic [HR_W*N_MODES-1:0]  i_hr_bus;

  logic [N_MODES-1:0]       o_set;
  logic [N_MODES-1:0]       o_up;
  logic [N_MODES-1:0]       o_down;
  logic [N_MODES-1:0]       o_left;
  logic [N_MODES-1:0]       o_right;
  logic [SEC_W-1:0]         o_sec;
  logic [MIN_W-1:0]         o_min;
  logic [HR_W-1:0]          o_hr;
  logic [MW-1:0]            o_mode;
  logic                     o_mode_change;
  logic                     o_ms_pulse;

  // The hub side: consumes buttons and buses, drives everything else.
  modport slave (
    input  i_mode, i_set, i_up, i_down, i_left, i_right,
    input  i_sec_bus, i_min_bus, i_hr_bus,
    output o_set, o_up, o_down, o_left, o_right,
    output o_sec, o_min, o_hr, o_mode, o_mode_change, o_ms_pulse
  );

  // The panel / mode-module side.
  modport master (
    output i_mode, i_set, i_up, i_down, i_left, i_right,
    output i_sec_bus, i_min_bus, i_hr_bus,
    input  o_set, o_up, o_down, o_left, o_right,
    input  o_sec, o_min, o_hr, o_mode, o_mode_change, o_ms_pulse
  );

endinterface

// File: rtl/ms_tick_gen.sv
// Free-running divider producing a one-cycle 1 ms tick shared by all modes.
module ms_tick_gen #(
  parameter int MS_DIV = 50000
) (
  input  logic i_clk,
  input  logic i_rstn,
  output logic o_ms_pulse
);

  localparam int CW = $clog2(MS_DIV);
  localparam logic [CW-1:0] LAST = CW'(MS_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..MS_DIV-1 and flag the cycle after the terminal count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt        <= '0;
      o_ms_pulse <= 1'b0;
    end else begin
      o_ms_pulse <= (cnt == LAST);
      cnt        <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mode_hub.sv
// Mode-selection hub: tracks the active mode from the mode button (short
// press = next, long press = mode 0), routes button pulses to the active
// mode and registers that mode's time fields onto the display.
module mode_hub
  import clock_pkg::*;
#(
  parameter int N_MODES = 3,
  parameter int MS_DIV  = 50000,
  parameter int HOLD_MS = 1000
) (
  input logic        i_clk,
  input logic        i_rstn,
  mode_hub_if.slave  hub
);

  localparam int MW = mode_w(N_MODES);
  localparam int HW = $clog2(HOLD_MS + 1);
  localparam logic [MW-1:0] LAST_MODE = MW'(N_MODES - 1);
  localparam logic [MW-1:0] HOME_MODE = MW'(MODE_CLOCK);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MS - 1);

  logic               ms_pulse;
  logic [5:0]         btn;
  logic [5:0]         btn_prev;
  logic [5:0]         btn_rise;
  mode_state_e        state;
  logic [HW-1:0]      hold_cnt;
  logic [MW-1:0]      r_mode;
  logic               mode_change;
  logic [N_MODES-1:0] sel_oh;

  ms_tick_gen #(.MS_DIV(MS_DIV)) u_tick (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .o_ms_pulse (ms_pulse)
  );

  // Bit order: mode, set, up, down, left, right.
  assign btn      = {hub.i_mode, hub.i_set, hub.i_up, hub.i_down, hub.i_left, hub.i_right};
  assign btn_rise = btn & ~btn_prev;
  assign sel_oh   = N_MODES'(1) << r_mode;

  assign hub.o_ms_pulse    = ms_pulse;
  assign hub.o_mode        = r_mode;
  assign hub.o_mode_change = mode_change;

  // Previous button levels; reset high so a button held through reset
  // release must be let go and pressed again before it produces a pulse.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) btn_prev <= '1;
    else         btn_prev <= btn;
  end

  // Mode-button FSM: hold timing, mode index and change pulse.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      r_mode      <= '0;
      mode_change <= 1'b0;
    end else begin
      mode_change <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_rise[5]) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (!hub.i_mode) begin
            // Release before the hold expired: step to the next mode.
            state       <= IDLE;
            r_mode      <= (r_mode == LAST_MODE) ? '0 : r_mode + MW'(1);
            mode_change <= 1'b1;
          end else if (ms_pulse) begin
            if (hold_cnt == HOLD_LAST) begin
              state       <= LONG;
              r_mode      <= HOME_MODE;
              mode_change <= (r_mode != HOME_MODE);
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        LONG: begin
          if (!hub.i_mode) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route each data-button edge to the currently active mode only.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hub.o_set   <= '0;
      hub.o_up    <= '0;
      hub.o_down  <= '0;
      hub.o_left  <= '0;
      hub.o_right <= '0;
    end else begin
      hub.o_set   <= btn_rise[4] ? sel_oh : '0;
      hub.o_up    <= btn_rise[3] ? sel_oh : '0;
      hub.o_down  <= btn_rise[2] ? sel_oh : '0;
      hub.o_left  <= btn_rise[1] ? sel_oh : '0;
      hub.o_right <= btn_rise[0] ? sel_oh : '0;
    end
  end

  // Register the active mode's time fields for the display.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hub.o_sec <= '0;
      hub.o_min <= '0;
      hub.o_hr  <= '0;
    end else begin
      hub.o_sec <= hub.i_sec_bus[SEC_W*int'(r_mode) +: SEC_W];
      hub.o_min <= hub.i_min_bus[MIN_W*int'(r_mode) +: MIN_W];
      hub.o_hr  <= hub.i_hr_bus[HR_W*int'(r_mode) +: HR_W];
    end
  end

endmodule

// File: tb/tb_mode_hub.sv
// Directed bench for mode_hub: a 3-mode instance for presses, routing,
// display and reset, and a 5-mode instance for non-power-of-two wrap.
module tb_mode_hub;
  import clock_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  mode_hub_if #(.N_MODES(3)) ifa ();
  mode_hub_if #(.N_MODES(5)) ifb ();

  mode_hub #(.N_MODES(3), .MS_DIV(4), .HOLD_MS(3)) dut_a (
    .i_clk  (clk),
    .i_rstn (rstn),
    .hub    (ifa.slave)
  );

  mode_hub #(.N_MODES(5), .MS_DIV(4), .HOLD_MS(3)) dut_b (
    .i_clk  (clk),
    .i_rstn (rstn),
    .hub    (ifb.slave)
  );

  int n_checks  = 0;
  int n_pass    = 0;
  int range_bad = 0;
  int ms_bad    = 0;
  int ms_pulses = 0;
  int ms_gap    = 0;
  bit ms_seen   = 1'b0;

  int n_mc;
  int tick_cnt;
  int ticks_at_mc;
  int mode_at_mc;
  logic [2:0] acc;

  // Tick period watcher on the 3-mode instance, restarted by reset.
  always @(negedge clk) begin
    if (!rstn) begin
      ms_seen = 1'b0;
      ms_gap  = 0;
    end else begin
      ms_gap++;
      if (ifa.o_ms_pulse) begin
        if (ms_seen && ms_gap != 4) ms_bad++;
        ms_pulses++;
        ms_seen = 1'b1;
        ms_gap  = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ifb.o_mode > 3'd4) range_bad++;
  endtask

  // Hold the mode button for two cycles, release, and check the step.
  task automatic short_press(input bit on_b, input int exp_mode, input string tag);
    if (on_b) ifb.i_mode = 1'b1; else ifa.i_mode = 1'b1;
    tick();
    tick();
    if (on_b) ifb.i_mode = 1'b0; else ifa.i_mode = 1'b0;
    tick();
    check({tag, "_mode"}, on_b ? 32'(ifb.o_mode) : 32'(ifa.o_mode), 32'(exp_mode));
    check({tag, "_chg"}, on_b ? 32'(ifb.o_mode_change) : 32'(ifa.o_mode_change), 32'd1);
    tick();
    check({tag, "_chg_off"}, on_b ? 32'(ifb.o_mode_change) : 32'(ifa.o_mode_change), 32'd0);
  endtask

  initial begin
    {ifa.i_mode, ifa.i_set, ifa.i_up, ifa.i_down, ifa.i_left, ifa.i_right} = '0;
    {ifb.i_mode, ifb.i_set, ifb.i_up, ifb.i_down, ifb.i_left, ifb.i_right} = '0;
    for (int k = 0; k < 3; k++) begin
      ifa.i_sec_bus[6*k +: 6] = 6'(k + 10);
      ifa.i_min_bus[6*k +: 6] = 6'(k + 20);
      ifa.i_hr_bus[5*k +: 5]  = 5'(k + 1);
    end
    for (int k = 0; k < 5; k++) begin
      ifb.i_sec_bus[6*k +: 6] = 6'(k + 10);
      ifb.i_min_bus[6*k +: 6] = 6'(k + 20);
      ifb.i_hr_bus[5*k +: 5]  = 5'(k + 1);
    end

    // Reset state
    tick(); tick(); tick();
    check("rst_mode", 32'(ifa.o_mode), 32'd0);
    check("rst_sec", 32'(ifa.o_sec), 32'd0);
    check("rst_chg", 32'(ifa.o_mode_change), 32'd0);
    check("rst_ms", 32'(ifa.o_ms_pulse), 32'd0);
    check("rst_up", 32'(ifa.o_up), 32'd0);
    rstn = 1'b1;
    tick(); tick();
    check("disp_mode0_sec", 32'(ifa.o_sec), 32'd10);

    // Short presses: 1, 2, 0
    short_press(1'b0, 1, "sp1");
    short_press(1'b0, 2, "sp2");
    short_press(1'b0, 0, "sp3");

    // Long press from mode 2
    short_press(1'b0, 1, "sp4");
    short_press(1'b0, 2, "sp5");
    ifa.i_mode = 1'b1;
    n_mc = 0; tick_cnt = 0; ticks_at_mc = -1; mode_at_mc = 7;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ifa.o_mode_change) begin
        n_mc++;
        ticks_at_mc = tick_cnt;
        mode_at_mc  = int'(ifa.o_mode);
      end
      if (ifa.o_ms_pulse) tick_cnt++;
    end
    check("long_chg_count", 32'(n_mc), 32'd1);
    check("long_after_ticks", 32'(ticks_at_mc), 32'd3);
    check("long_mode_at_chg", 32'(mode_at_mc), 32'd0);
    ifa.i_mode = 1'b0;
    n_mc = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ifa.o_mode_change) n_mc++;
    end
    check("long_release_chg", 32'(n_mc), 32'd0);
    check("long_release_mode", 32'(ifa.o_mode), 32'd0);

    // Long press while already in mode 0
    ifa.i_mode = 1'b1;
    n_mc = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ifa.o_mode_change) n_mc++;
    end
    ifa.i_mode = 1'b0;
    tick(); tick();
    check("long0_chg", 32'(n_mc), 32'd0);
    check("long0_mode", 32'(ifa.o_mode), 32'd0);

    // Routing in mode 1
    short_press(1'b0, 1, "sp6");
    ifa.i_up = 1'b1;
    tick();
    check("up_route", 32'(ifa.o_up), 32'b010);
    tick();
    check("up_one_cycle", 32'(ifa.o_up), 32'd0);
    acc = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      acc |= ifa.o_up;
    end
    check("up_held", 32'(acc), 32'd0);
    ifa.i_up = 1'b0;
    tick();

    // Mode rise never routes; right edge with release goes to old mode
    ifa.i_mode = 1'b1;
    tick();
    check("mode_rise_no_route",
          32'({ifa.o_set, ifa.o_up, ifa.o_down, ifa.o_left, ifa.o_right}), 32'd0);
    tick();
    ifa.i_mode  = 1'b0;
    ifa.i_right = 1'b1;
    tick();
    check("right_old_mode", 32'(ifa.o_right), 32'b010);
    check("right_new_mode", 32'(ifa.o_mode), 32'd2);
    check("right_chg", 32'(ifa.o_mode_change), 32'd1);
    ifa.i_right = 1'b0;
    tick();
    check("right_off", 32'(ifa.o_right), 32'd0);

    // Display mux two cycles after the release
    check("disp_sec", 32'(ifa.o_sec), 32'd12);
    check("disp_min", 32'(ifa.o_min), 32'd22);
    check("disp_hr", 32'(ifa.o_hr), 32'd3);

    // Reset during a long press in mode 2
    ifa.i_mode = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    rstn = 1'b0;
    #1;
    check("arst_mode", 32'(ifa.o_mode), 32'd0);
    check("arst_fields", 32'({ifa.o_sec, ifa.o_min, ifa.o_hr}), 32'd0);
    check("arst_chg", 32'(ifa.o_mode_change), 32'd0);
    ifa.i_mode = 1'b0;
    ifa.i_up   = 1'b1;
    tick(); tick();
    rstn = 1'b1;
    acc = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      acc |= ifa.o_up;
    end
    check("up_held_through_reset", 32'(acc), 32'd0);
    check("arst_disp_sec", 32'(ifa.o_sec), 32'd10);
    ifa.i_up = 1'b0;
    tick();
    ifa.i_up = 1'b1;
    tick();
    check("up_repress", 32'(ifa.o_up), 32'b001);
    ifa.i_up = 1'b0;
    tick();
    check("up_repress_off", 32'(ifa.o_up), 32'd0);

    // Five-mode wrap
    short_press(1'b1, 1, "b_sp1");
    short_press(1'b1, 2, "b_sp2");
    short_press(1'b1, 3, "b_sp3");
    short_press(1'b1, 4, "b_sp4");
    short_press(1'b1, 0, "b_sp5");
    check("b_range", 32'(range_bad), 32'd0);

    // Tick period over the whole run
    check("ms_period", 32'(ms_bad), 32'd0);
    check("ms_seen", 32'(ms_pulses > 20), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mode_hub.md
# mode_hub

`mode_hub` is the parametrised mode-selection hub that sits between the front-panel buttons and the N time-keeping mode modules (clock, stopwatch, timer, …). It tracks the active mode from the mode button: a short press advances to the next mode and a long press returns to mode 0. It converts the level button inputs into one-cycle pulses, routes those pulses only to the active mode, and registers the selected mode's time fields onto the display outputs. It also generates the shared 1 ms tick used by all mode modules.

## Interface
- `N_MODES`, default 3: number of mode modules; must be ≥ 2.
- `MS_DIV`, default 50000: `i_clk` cycles per 1 ms tick; must be ≥ 2.
- `HOLD_MS`, default 1000: mode-button hold time, in ms ticks, that counts as a long press; must be ≥ 1.
- Derived: `MW = max(1, $clog2(N_MODES))`.

Ports (clock and reset first):
- `i_clk`  in  1  single clock.
- `i_rstn`  in  1  reset, asynchronous, active-low.
- `i_mode`, `i_set`, `i_up`, `i_down`, `i_left`, `i_right`  in  1 each  level button inputs, already synchronous to `i_clk` and debounced.
- `i_sec_bus`  in  6·N_MODES  packed seconds, one per mode; mode k occupies `[6k+5:6k]`.
- `i_min_bus`  in  6·N_MODES  packed minutes, same packing.
- `i_hr_bus`  in  5·N_MODES  packed hours; mode k occupies `[5k+4:5k]`.
- `o_set`, `o_up`, `o_down`, `o_left`, `o_right`  out  N_MODES each  one-hot routed button pulses; bit k goes to mode k.
- `o_sec` out 6, `o_min` out 6, `o_hr` out 5: display fields of the active mode.
- `o_mode`  out  MW  active mode index.
- `o_mode_change`  out  1  one-cycle pulse whenever `o_mode` changes.
- `o_ms_pulse`  out  1  one-cycle tick every MS_DIV cycles.

## Operation
**Reset values.** Every output is 0 and all counters are 0. The button previous-state registers reset to 1, so a button held through reset release produces no pulse until it has been released and pressed again.

**ms tick.** A free-running counter runs 0..MS_DIV−1. `o_ms_pulse` is 1 in the cycle after the counter equals MS_DIV−1.

**Button pulses.**
- A rising edge on `i_set`, `i_up`, `i_down`, `i_left` or `i_right` in cycle t drives bit `r_mode` (the value in cycle t) of the matching output high in cycle t+1 only.
- All other bits stay 0, and the outputs are never multi-hot.

**Mode FSM.** States are IDLE, PRESSED and LONG.
- IDLE → PRESSED on a rising edge of `i_mode`; the hold counter is cleared.
- In PRESSED, each `o_ms_pulse` increments the hold counter.
  - If the counter reaches HOLD_MS: go to LONG and set `r_mode` to 0.
  - If `i_mode` falls first: go to IDLE and set `r_mode` to `(r_mode == N_MODES−1) ? 0 : r_mode+1`.
- LONG → IDLE when `i_mode` falls; the release does not advance the mode.
- Long press while already in mode 0: `r_mode` stays 0 and `o_mode_change` is not pulsed.
- `r_mode` never exceeds N_MODES−1, including when N_MODES is not a power of two.

**Simultaneous events.**
- A data-button edge in the same cycle as a mode update routes to the old mode.
- A rising edge on `i_mode` has no effect on the data-button pulse outputs.

**Display mux.** Registered: `o_sec`/`o_min`/`o_hr` take the slice selected by `r_mode`.

**Reset mid-operation.** Reset returns the FSM to IDLE and `r_mode` to 0 immediately (asynchronous). A press in progress is discarded.

## Timing
- Short press: `i_mode` falls in cycle t → `o_mode` holds the new index and `o_mode_change` = 1 in cycle t+1 → the display shows the new mode's fields in cycle t+2.
- Long press: the ms tick that makes the hold counter equal HOLD_MS, in cycle t → `o_mode` = 0 and `o_mode_change` pulse in cycle t+1.
- Button pulse latency is 1 cycle. Display latency is 1 cycle from a `r_mode` or `i_*_bus` change.
- `o_mode_change` is high for exactly the one cycle in which `o_mode` first shows its new value.

## Structure
- Shared package `clock_pkg` holds:
  - `SEC_W = 6`, `MIN_W = 6`, `HR_W = 5`.
  - The mode index constants `MODE_CLOCK = 0`, `MODE_STOPWATCH = 1`, `MODE_TIMER = 2`.
  - The mode-FSM state enum.
- Sub-module `ms_tick_gen`, parameterised by `MS_DIV`, produces `o_ms_pulse`; all mode modules share it. Everything else lives in `mode_hub`.

## Test plan
Unless stated otherwise, the bench uses N_MODES=3, MS_DIV=4, HOLD_MS=3.
1. **Short presses:** three short `i_mode` presses (each held < 12 cycles) → `o_mode` goes 1, 2, 0, with exactly one `o_mode_change` pulse per release.
2. **Long press:** from mode 2, hold `i_mode` for 20 cycles → `o_mode` = 0 after the 3rd ms tick, one `o_mode_change` pulse, and no further change on release.
3. **Routing:** in mode 1, pulse `i_up` once → `o_up` = 3'b010 for exactly 1 cycle. Holding `i_up` high produces no further pulses. Pressing `i_right` and releasing `i_mode` in the same cycle → `o_right` = 3'b010.
4. **Display mux:** per-mode values sec/min/hr = (k+10, k+20, k+1) → after switching to mode 2, `o_sec`/`o_min`/`o_hr` = 12/22/3 two cycles after the release.
5. **Reset behaviour:** assert `i_rstn` low during a long press in mode 2 → all outputs 0 and `o_mode` = 0. Keep `i_up` high through reset release → no `o_up` pulse until it is re-pressed.
6. **Non-power-of-two wrap:** with N_MODES=5, press `i_mode` briefly 5 times → `o_mode` goes 1, 2, 3, 4, 0 and never shows 5–7. `o_ms_pulse` period is exactly 4 cycles throughout.
